// File: rtl/mem_responder.sv
// mem_responder: responder side of the CPU data-memory handshake.
// One word read or write on an internal synchronous array per accepted order,
// completed after LATENCY cycles with a one-cycle registered accessed pulse.
// Only one access may be outstanding; orders seen while busy are dropped.
module mem_responder #(
  parameter int LEN_WORD     = 32,
  parameter int LEN_MEM_ADDR = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int LATENCY      = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    order,
  input  logic                    io,
  input  logic [LEN_MEM_ADDR-1:0] addr,
  input  logic [LEN_WORD-1:0]     wdata,
  output logic                    accessed,
  output logic [LEN_WORD-1:0]     rdata,
  output logic                    busy,
  output logic                    err
);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("mem_responder: LATENCY must lie in 1..255");
    end
  endgenerate

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         HI_W     = LEN_MEM_ADDR - DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [7:0]              cnt_r, cnt_s;
  logic                    io_r;
  logic [LEN_MEM_ADDR-1:0] addr_r;
  logic [LEN_WORD-1:0]     wdata_r;
  logic                    accessed_r;
  logic [LEN_WORD-1:0]     rdata_r;
  logic                    busy_r;
  logic                    err_r;
  logic [LEN_WORD-1:0]     mem_r [DEPTH];

  logic                    req_io_s;
  logic [LEN_MEM_ADDR-1:0] req_addr_s;
  logic [LEN_WORD-1:0]     req_wdata_s;
  logic                    accept_s;
  logic                    commit_s;
  logic                    in_range_s;
  logic [DEPTH_LOG2-1:0]   idx_s;

  // Pick the live request in IDLE (LATENCY==1 commits on the accepting edge), else the latched one.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && order;
    if (state_r == ST_IDLE) begin
      req_io_s    = io;
      req_addr_s  = addr;
      req_wdata_s = wdata;
    end else begin
      req_io_s    = io_r;
      req_addr_s  = addr_r;
      req_wdata_s = wdata_r;
    end
    in_range_s = (req_addr_s[LEN_MEM_ADDR-1:DEPTH_LOG2] == {HI_W{1'b0}});
    idx_s      = req_addr_s[DEPTH_LOG2-1:0];
  end

  // Next-state and latency counter; commit is the edge that enters DONE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (order) begin
          cnt_s = CNT_INIT;
          if (CNT_INIT == 8'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 8'd1) begin
          state_s = ST_DONE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    commit_s = (state_s == ST_DONE) && (state_r != ST_DONE);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      io_r    <= 1'b0;
      addr_r  <= {LEN_MEM_ADDR{1'b0}};
      wdata_r <= {LEN_WORD{1'b0}};
    end else if (accept_s) begin
      io_r    <= io;
      addr_r  <= addr;
      wdata_r <= wdata;
    end
  end

  // Storage array: contents survive reset; a reset on the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (rstn && commit_s && req_io_s && in_range_s) begin
      mem_r[idx_s] <= req_wdata_s;
    end
  end

  // Registered handshake outputs; rdata/err only change on commit, err clears on acceptance.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      accessed_r <= 1'b0;
      busy_r     <= 1'b0;
      rdata_r    <= {LEN_WORD{1'b0}};
      err_r      <= 1'b0;
    end else begin
      accessed_r <= (state_s == ST_DONE);
      busy_r     <= (state_s != ST_IDLE);
      if (commit_s) begin
        err_r <= !in_range_s;
        if (!in_range_s) begin
          rdata_r <= {LEN_WORD{1'b0}};
        end else if (req_io_s) begin
          rdata_r <= req_wdata_s;
        end else begin
          rdata_r <= mem_r[idx_s];
        end
      end else if (accept_s) begin
        err_r <= 1'b0;
      end
    end
  end

  assign accessed = accessed_r;
  assign rdata    = rdata_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven directed vectors, hand-written corner sequences
// and randomized traffic against an array-based reference model.
module tb_mem_responder;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        order, io;
  logic [31:0] addr, wdata;
  logic        accessed, busy, err;
  logic [31:0] rdata;
  logic        order1, io1;
  logic [31:0] addr1, wdata1;
  logic        accessed1, busy1, err1;
  logic [31:0] rdata1;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .order(order), .io(io), .addr(addr), .wdata(wdata),
    .accessed(accessed), .rdata(rdata), .busy(busy), .err(err)
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .order(order1), .io(io1), .addr(addr1), .wdata(wdata1),
    .accessed(accessed1), .rdata(rdata1), .busy(busy1), .err(err1)
  );

  typedef struct {
    logic        io;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] prev_rdata;
  vec_t        vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: word array, high address bits must be zero.
  task automatic model_apply(input logic m_io, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic e);
    if (a[31:10] != 22'd0) begin
      rd = 32'd0;
      e  = 1'b1;
    end else begin
      e = 1'b0;
      if (m_io) begin
        model_mem[a[9:0]] = d;
        rd = d;
      end else begin
        rd = model_mem[a[9:0]];
      end
    end
  endtask

  // One access on the main DUT, starting at a negedge with the DUT idle.
  task automatic txn(input logic t_io, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input bit noise,
                     input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    io = t_io; addr = t_addr; wdata = t_wdata; order = 1'b1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_err_clear"}, 32'(err), 32'd0);
        chk({tag, "_rdata_hold_pre"}, rdata, prev_rdata);
      end
      if (accessed) begin
        got = 1'b1;
        chk({tag, "_latency"}, 32'(n), 32'(L));
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      end else begin
        chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
        if (noise) begin
          order = 1'($urandom_range(0, 1));
          io = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        end else begin
          order = 1'b0;
        end
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: no accessed pulse within 40 cycles", tag);
    end
    if (noise) begin
      order = 1'b1; io = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
    end else begin
      order = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(accessed), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_rdata_hold_post"}, rdata, exp_rd);
    order = 1'b0;
    prev_rdata = exp_rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] raddr;
    logic        rio;
    logic [31:0] rwd;
    bit          acc_pat [4];
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    vecs[0]  = '{1'b0, 32'd5,          32'd0,          32'd0,          1'b0};
    vecs[1]  = '{1'b1, 32'd5,          32'hDEADBEEF,   32'hDEADBEEF,   1'b0};
    vecs[2]  = '{1'b0, 32'd5,          32'd0,          32'hDEADBEEF,   1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0400,  32'd0,          32'd0,          1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0405,  32'h1111_1111,  32'd0,          1'b1};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hDEADBEEF,   1'b0};
    vecs[6]  = '{1'b1, 32'd7,          32'h0000_7777,  32'h0000_7777,  1'b0};
    vecs[7]  = '{1'b1, 32'd1023,       32'hA5A5_A5A5,  32'hA5A5_A5A5,  1'b0};
    vecs[8]  = '{1'b0, 32'd1023,       32'd0,          32'hA5A5_A5A5,  1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'd0,          32'd0,          1'b1};
    vecs[10] = '{1'b0, 32'd0,          32'd0,          32'd0,          1'b0};

    rstn = 1'b0; order = 1'b1; io = 1'b1; addr = 32'd3; wdata = 32'hFFFF_FFFF;
    order1 = 1'b1; io1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    prev_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_accessed", 32'(accessed), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_accessed1", 32'(accessed1), 32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    rstn = 1'b1; order = 1'b0; order1 = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].io, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
          (i % 2) == 1, $sformatf("vec%0d", i));
      model_apply(vecs[i].io, vecs[i].addr, vecs[i].wdata, erd, eerr);
    end

    // Reset one cycle before the commit of a write aborts it.
    io = 1'b1; addr = 32'd7; wdata = 32'h0000_1234; order = 1'b1;
    @(negedge clk);
    order = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("abort_accessed", 32'(accessed), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(accessed), 32'd0);
    end
    prev_rdata = 32'd0;
    txn(1'b0, 32'd7, 32'd0, 32'h0000_7777, 1'b0, 1'b0, "abort_readback");

    // LATENCY==1 instance with order held high for four cycles.
    acc_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    io1 = 1'b1; addr1 = 32'd9; wdata1 = 32'hCAFE_0001; order1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat1_accessed_c%0d", c), 32'(accessed1), 32'(acc_pat[c]));
      chk($sformatf("lat1_busy_c%0d", c), 32'(busy1), 32'(acc_pat[c]));
      chk($sformatf("lat1_rdata_c%0d", c), rdata1, 32'hCAFE_0001);
    end
    order1 = 1'b0;
    @(negedge clk);
    chk("lat1_quiet", 32'(accessed1), 32'd0);
    io1 = 1'b0; order1 = 1'b1;
    @(negedge clk);
    order1 = 1'b0;
    chk("lat1_read_accessed", 32'(accessed1), 32'd1);
    chk("lat1_read_rdata", rdata1, 32'hCAFE_0001);
    chk("lat1_read_err", 32'(err1), 32'd0);
    @(negedge clk);
    chk("lat1_read_single", 32'(accessed1), 32'd0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      int r;
      r   = $urandom_range(0, 9);
      rio = 1'($urandom_range(0, 1));
      rwd = $urandom;
      if (r == 0) raddr = $urandom | 32'h0000_0400;
      else if (r == 1) raddr = 32'd1023;
      else raddr = 32'($urandom_range(0, 15));
      model_apply(rio, raddr, rwd, erd, eerr);
      txn(rio, raddr, rwd, erd, eerr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
